// File: rtl/video_stream_tx.sv
// video_stream_tx: frame timing generator that wraps upstream pixels in vsync/href/de
// with programmable horizontal and vertical blanking.
module video_stream_tx #(
   parameter int IMAGE_HSIZE      = 1280,
   parameter int IMAGE_VSIZE      = 720,
   parameter int H_BLANK_CYC      = 16,
   parameter int V_BACK_CYC       = 32,
   parameter int V_FRONT_CYC      = 32,
   parameter int V_GAP_CYC        = 64,
   parameter int PIXEL_DATA_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        pix_valid,
   input  logic [PIXEL_DATA_WIDTH-1:0] pix_data,
   output logic                        pix_ready,
   output logic                        image_out_vsync,
   output logic                        image_out_href,
   output logic                        image_out_de,
   output logic [PIXEL_DATA_WIDTH-1:0] image_out_data,
   output logic                        frame_done,
   output logic [15:0]                 stall_cnt
);
   typedef enum logic [2:0] {IDLE, V_BACK, LINE, H_BLANK, V_FRONT, V_GAP} state_t;

   localparam logic [11:0] HS   = 12'(IMAGE_HSIZE);
   localparam logic [11:0] VS   = 12'(IMAGE_VSIZE);
   localparam logic [15:0] HB_L = 16'(H_BLANK_CYC - 1);
   localparam logic [15:0] VB_L = 16'(V_BACK_CYC - 1);
   localparam logic [15:0] VF_L = 16'(V_FRONT_CYC - 1);
   localparam logic [15:0] VG_L = 16'(V_GAP_CYC - 1);

   state_t                      state_q, state_d;
   logic [11:0]                 xcnt_q, xcnt_d, ycnt_q, ycnt_d;
   logic [15:0]                 cnt_q, cnt_d, stall_q, stall_d;
   logic                        de_q, hs;
   logic [PIXEL_DATA_WIDTH-1:0] data_q;

   assign pix_ready       = (state_q == LINE) && (xcnt_q < HS);
   assign hs              = pix_valid & pix_ready;
   assign image_out_vsync = (state_q != IDLE) && (state_q != V_GAP);
   assign image_out_href  = state_q == LINE;
   assign image_out_de    = de_q;
   assign image_out_data  = data_q;
   assign frame_done      = (state_q == V_FRONT) && (cnt_q == VF_L);
   assign stall_cnt       = stall_q;

   always_comb begin
      state_d = state_q;
      xcnt_d  = xcnt_q;
      ycnt_d  = ycnt_q;
      cnt_d   = cnt_q + 16'd1;
      stall_d = stall_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            state_d = enable ? V_BACK : IDLE;
         end
         V_BACK: if (cnt_q == VB_L) begin
            state_d = LINE;
            xcnt_d  = '0;
         end
         LINE: begin
            xcnt_d  = hs ? xcnt_q + 12'd1 : xcnt_q;
            stall_d = (pix_ready && !pix_valid && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
            state_d = (xcnt_q == HS) ? H_BLANK : LINE;
         end
         H_BLANK: if (cnt_q == HB_L) begin
            xcnt_d  = '0;
            state_d = (ycnt_q + 12'd1 < VS) ? LINE : V_FRONT;
            ycnt_d  = (ycnt_q + 12'd1 < VS) ? ycnt_q + 12'd1 : '0;
         end
         V_FRONT: state_d = (cnt_q == VF_L) ? V_GAP : V_FRONT;
         V_GAP:   if (cnt_q == VG_L) state_d = enable ? V_BACK : IDLE;
         default: state_d = IDLE;
      endcase
      // blanking counter restarts on every state entry, including LINE re-entry from H_BLANK
      if (state_d != state_q) cnt_d = '0;
      if (state_d == V_BACK && state_q != V_BACK) stall_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         xcnt_q  <= '0;
         ycnt_q  <= '0;
         cnt_q   <= '0;
         stall_q <= '0;
         de_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         xcnt_q  <= xcnt_d;
         ycnt_q  <= ycnt_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         de_q    <= hs;
         if (hs) data_q <= pix_data;
      end
   end
endmodule

// File: tb/tb_video_stream_tx.sv
// tb_video_stream_tx: checks the generated frame timing against interval rules and
// a pixel scoreboard, plus literal timing expectations for the scripted frames.
module tb_video_stream_tx;
   localparam int HS = 4, VS = 2, HB = 2, VB = 3, VF = 2, VG = 3;

   logic        clk, rst_n, enable, pix_valid, pix_ready;
   logic [7:0]  pix_data, image_out_data;
   logic        image_out_vsync, image_out_href, image_out_de, frame_done;
   logic [15:0] stall_cnt;

   video_stream_tx #(
      .IMAGE_HSIZE(HS), .IMAGE_VSIZE(VS), .H_BLANK_CYC(HB), .V_BACK_CYC(VB),
      .V_FRONT_CYC(VF), .V_GAP_CYC(VG), .PIXEL_DATA_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_ready(pix_ready), .image_out_vsync(image_out_vsync),
      .image_out_href(image_out_href), .image_out_de(image_out_de),
      .image_out_data(image_out_data), .frame_done(frame_done), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // pixel source: incrementing data, optional random or scripted stalls
   int  pcount = 0, stall_trig = 10, stall_left = 0;
   bit  rnd = 0, took;
   initial begin
      pix_valid = 1'b0;
      pix_data  = 8'd0;
      forever begin
         @(negedge clk);
         took = pix_valid && pix_ready;
         @(posedge clk);
         #1;
         if (took) pcount++;
         pix_data = pcount[7:0];
         if (took && pcount == stall_trig) stall_left = 3;
         if (stall_left > 0) begin
            pix_valid = 1'b0;
            stall_left--;
         end else pix_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      end
   end

   // reference model: positions within the frame derived from observed edges,
   // next-cycle expectations derived from blanking lengths and accepted pixel counts
   logic [7:0] q[$], seen[$];
   int  len_q[$], gap_q[$], bp_q[$], fd_stall[$];
   int  low_cnt, lines, acc, stall_m, vpos, bcnt, de_line, de_frame, win, fd_cnt = 0;
   int  last_data;
   bit  prev_vs, prev_href, prev_hs, exp_vs, exp_href, after_frame, fd;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_vs = 0; prev_href = 0; prev_hs = 0; exp_href = 0; exp_vs = enable;
         low_cnt = VG; lines = 0; acc = 0; stall_m = 0; last_data = 0; after_frame = 0;
         vpos = 0; bcnt = 0; de_line = 0; de_frame = 0; win = 0;
      end else begin
         if (image_out_vsync && !prev_vs) begin
            vpos = 0; lines = 0; stall_m = 0; de_frame = 0;
            if (after_frame) gap_q.push_back(low_cnt + 1);
         end else vpos++;
         if (!image_out_vsync) low_cnt = prev_vs ? 0 : low_cnt + 1;
         if (image_out_href && !prev_href) begin
            acc = 0; de_line = 0; win = 0;
            if (lines == 0) bp_q.push_back(vpos);
         end
         if (!image_out_href && prev_href) begin
            lines++; bcnt = 0;
            chk("crop_de_per_line", de_line, HS);
            len_q.push_back(win);
         end else bcnt++;
         if (!image_out_vsync && prev_vs) begin
            after_frame = 1;
            chk("crop_lines_per_frame", lines, VS);
            chk("crop_de_per_frame", de_frame, HS * VS);
         end
         if (image_out_href) win++;
         fd = image_out_vsync && !image_out_href && lines == VS && bcnt == HB + VF - 1;
         chk("vsync", int'(image_out_vsync), int'(exp_vs));
         chk("href", int'(image_out_href), int'(exp_href));
         chk("de", int'(image_out_de), int'(prev_hs));
         chk("pix_ready", int'(pix_ready), int'(image_out_href && acc < HS));
         chk("frame_done", int'(frame_done), int'(fd));
         chk("stall_cnt", int'(stall_cnt), stall_m);
         if (image_out_de) begin
            chk("de_has_pixel", int'(q.size() > 0), 1);
            if (q.size() > 0) last_data = int'(q.pop_front());
            chk("data", int'(image_out_data), last_data);
            de_line++; de_frame++;
            seen.push_back(image_out_data);
         end else chk("data_hold", int'(image_out_data), last_data);
         if (frame_done) begin
            fd_cnt++;
            fd_stall.push_back(int'(stall_cnt));
         end
         exp_vs   = image_out_vsync ? !fd : (low_cnt >= VG - 1 && enable);
         exp_href = image_out_href ? (acc != HS) :
                    (image_out_vsync && ((lines == 0 && vpos == VB - 1) ||
                                         (lines > 0 && lines < VS && bcnt == HB - 1)));
         prev_hs = pix_valid && pix_ready;
         if (prev_hs) begin
            q.push_back(pix_data);
            acc++;
         end
         if (pix_ready && !pix_valid && stall_m < 65535) stall_m++;
         prev_vs = image_out_vsync;
         prev_href = image_out_href;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_vsync"}, int'(image_out_vsync), 0);
      chk({tag, "_href"}, int'(image_out_href), 0);
      chk({tag, "_de"}, int'(image_out_de), 0);
      chk({tag, "_data"}, int'(image_out_data), 0);
      chk({tag, "_ready"}, int'(pix_ready), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_stall"}, int'(stall_cnt), 0);
   endtask

   int n, fdb;
   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      #2;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      // frames 1 and 2: constant valid, scripted 3-cycle stall in frame 2
      @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      chk("vs_before_rise", int'(image_out_vsync), 0);
      @(negedge clk);
      chk("vs_rise", int'(image_out_vsync), 1);
      for (n = 0; n < 300 && fd_cnt < 2; n++) @(negedge clk);
      chk("frames_timeout", int'(fd_cnt >= 2), 1);
      stall_trig = -1;
      chk("seen_count", int'(seen.size() >= 16), 1);
      for (int k = 0; k < 16 && k < seen.size(); k++) chk("seen_order", int'(seen[k]), k);
      chk("bp_len", bp_q.size() > 0 ? bp_q[0] : -1, 3);
      chk("gap_len", gap_q.size() > 0 ? gap_q[0] : -1, 3);
      chk("len_count", int'(len_q.size() >= 4), 1);
      if (len_q.size() >= 4) begin
         chk("href_len0", len_q[0], 5);
         chk("href_len1", len_q[1], 5);
         chk("href_len_stall", len_q[2], 8);
         chk("href_len3", len_q[3], 5);
      end
      chk("fd_stall_count", int'(fd_stall.size()), 2);
      if (fd_stall.size() >= 2) begin
         chk("fd_stall0", fd_stall[0], 0);
         chk("fd_stall1", fd_stall[1], 3);
      end
      // random stalls; drop enable in line 1, frame must finish then idle
      rnd = 1;
      for (n = 0; n < 500 && !(lines == 1 && image_out_href && image_out_vsync); n++) @(negedge clk);
      chk("line1_timeout", int'(lines == 1 && image_out_href), 1);
      fdb = fd_cnt;
      @(posedge clk);
      #1 enable = 1'b0;
      for (n = 0; n < 500 && image_out_vsync; n++) @(negedge clk);
      chk("vs_fall_timeout", int'(image_out_vsync), 0);
      chk("fd_after_drop", fd_cnt, fdb + 1);
      repeat (15) @(negedge clk);
      chk("idle_vsync", int'(image_out_vsync), 0);
      chk("idle_fd", fd_cnt, fdb + 1);
      @(posedge clk);
      #1 enable = 1'b1;
      for (n = 0; n < 10 && !image_out_vsync; n++) @(negedge clk);
      chk("restart_vsync", int'(image_out_vsync), 1);
      chk("restart_stall_clr", int'(stall_cnt), 0);
      // asynchronous reset in the middle of line 1
      for (n = 0; n < 500 && !(lines == 1 && image_out_href && image_out_vsync); n++) @(negedge clk);
      chk("line1b_timeout", int'(lines == 1 && image_out_href), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      n = bp_q.size();
      for (int i = 0; i < 50 && bp_q.size() == n; i++) @(negedge clk);
      chk("post_reset_bp", bp_q.size() > n ? bp_q[$] : -1, 3);
      // random enable toggling over many frames
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(60) == 0) enable = ~enable;
      end
      @(negedge clk);
      chk("frames_seen", int'(fd_cnt > 4), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/video_stream_tx.md
Name: video_stream_tx

Overview:
Transmit end of the vsync/href/de/data pixel-stream interface used across the stitching pipeline. It pulls pixels from an upstream FIFO or ready/valid source and generates a full frame of timing around them: vsync, href and de, with programmable blanking. The output stream is consumed directly by the crop, scaler and stitch stages. The block also serves as a frame source for simulation and for rebuilding a stream after a frame buffer.

Parameters:
IMAGE_HSIZE, 1280, active pixels per line (1..4095)
IMAGE_VSIZE, 720, active lines per frame (1..4095)
H_BLANK_CYC, 16, href-low cycles after each line (>=1)
V_BACK_CYC, 32, cycles with vsync high before the first href of a frame (>=1)
V_FRONT_CYC, 32, cycles with vsync high after the last line's blank (>=1)
V_GAP_CYC, 64, cycles with vsync low between frames (>=1)
PIXEL_DATA_WIDTH, 8, pixel width

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/continue frame generation; sampled only in IDLE and at the end of V_GAP
pix_valid  in  1  upstream pixel available
pix_data  in  PIXEL_DATA_WIDTH  upstream pixel
pix_ready  out  1  combinational; pixel accepted when pix_valid & pix_ready
image_out_vsync  out  1  high for the whole frame (data valid), low in the gap
image_out_href  out  1  high for the line window
image_out_de  out  1  high on cycles carrying a valid pixel
image_out_data  out  PIXEL_DATA_WIDTH  pixel data; holds its last value when de is low
frame_done  out  1  one-cycle pulse on the last V_FRONT cycle
stall_cnt  out  16  saturating count of LINE cycles with pix_ready=1 and pix_valid=0; cleared on entry to V_BACK

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including pix_ready. xcnt, ycnt and the cycle counter are 0. Reset mid-frame aborts the frame immediately; there is no flush.
- States: IDLE, V_BACK, LINE, H_BLANK, V_FRONT, V_GAP.
- vsync = 1 in V_BACK, LINE, H_BLANK and V_FRONT; 0 in IDLE and V_GAP. href = 1 exactly in LINE. Both come from the state register, not from the next-state logic.
- IDLE: if enable=1, go to V_BACK next cycle. Otherwise stay.
- V_BACK: count V_BACK_CYC cycles, then go to LINE with xcnt=0.
- LINE:
  - pix_ready = (xcnt < IMAGE_HSIZE).
  - On a handshake, xcnt increments. The next cycle drives de=1 and data=the accepted pix_data (1-cycle latency).
  - When xcnt == IMAGE_HSIZE, pix_ready=0 and the state leaves LINE on the next edge. The final pixel's de therefore falls in the last href cycle.
  - With no stalls, href is high IMAGE_HSIZE+1 cycles. De is low in the first href cycle and high in the remaining IMAGE_HSIZE.
  - Stalls (pix_valid=0) extend href and drop de. There is no timeout; href stays high until IMAGE_HSIZE pixels are accepted.
- H_BLANK: count H_BLANK_CYC cycles, then increment ycnt.
  - If the new ycnt < IMAGE_VSIZE, go to LINE (xcnt=0).
  - Otherwise go to V_FRONT (ycnt=0).
- V_FRONT: count V_FRONT_CYC cycles. frame_done=1 on the final cycle. Then go to V_GAP.
- V_GAP: count V_GAP_CYC cycles. On the final cycle, if enable=1 go to V_BACK, else go to IDLE.
- Enable deasserted mid-frame: the current frame completes normally, and the block then returns to IDLE after V_GAP.
- Outside LINE: pix_ready=0 and de=0, so no pixel is consumed in blanking even when pix_valid=1.
- Widths: xcnt and ycnt are 12 bits. The blanking counter is 16 bits and is reloaded on every state entry. stall_cnt saturates at 0xFFFF.
- Output invariants: the count of de pulses per href window is exactly IMAGE_HSIZE, and the count of href windows per vsync-high period is exactly IMAGE_VSIZE. The stream is compatible with an xpos counter clocked by de inside href and a ypos counter clocked on the href falling edge inside vsync.

Test Plan:
Bench parameters for all scenarios: IMAGE_HSIZE=4, IMAGE_VSIZE=2, H_BLANK_CYC=2, V_BACK_CYC=3, V_FRONT_CYC=2, V_GAP_CYC=3.
1. Reset, enable=1, pix_valid=1 constant with data 0,1,2,... -> vsync rises 1 cycle after enable seen. Href rises after 3 cycles and lasts 5 cycles each. De carries 0,1,2,3 on line 0 and 4,5,6,7 on line 1. 2-cycle gap between the lines. frame_done pulses once. Vsync low for 3 cycles, then the next frame starts with data 8.
2. Deassert pix_valid for 3 cycles after the 2nd pixel of line 0 -> href widens to 8 cycles, de low during the stall, stall_cnt=3, data order intact, pixel count still 4.
3. Drop enable in the middle of line 1 -> frame completes (both lines, V_FRONT, frame_done), then V_GAP, then IDLE with vsync=0. Re-assert -> new frame with stall_cnt cleared to 0.
4. Hold pix_valid=1 during V_BACK, H_BLANK and V_GAP -> pix_ready=0, no pixels consumed, de stays 0 outside href.
5. Assert rst_n low during line 1 -> all outputs 0 asynchronously. After release with enable=1, a fresh frame starts at ypos 0 with V_BACK of 3 cycles.
6. Loop the output into the crop stage (full-window crop) -> crop output de count = 8 per frame, 4 per href window, with matching data.
